rtc_regfile_calendar: RTL
=========================

# rtc_regfile_calendar

Parametrised RTC register file with a self-advancing calendar and countdown timer. Host-side logic writes and reads it through one write port and two registered read ports. A 1 Hz tick advances seconds through years, with month length and leap-year handling, and decrements the timer channel. It replaces the fixed 16×8 time memory between the tick generator, the host interface FSM and the display driver.

## Interface
- DATA_W, 8: register width; must be ≥ 8, upper bits read 0 for time fields
- ADDR_W, 4: address width; depth = 2**ADDR_W; must be ≥ 4
- TIMER_EN, 1: 1 = countdown timer logic present; 0 = addresses 9–11 act as plain storage
- clk  in  1  single clock; everything on rising edge
- reset  in  1  synchronous, active-high
- tick  in  1  one-cycle pulse, nominally 1 Hz
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rd_addr_a, rd_addr_b  in  ADDR_W  read addresses
- rd_data_a, rd_data_b  out  DATA_W  registered read data
- ptr_in  in  4  cursor pointer from host FSM, mirrored at address 12
- timer_done  out  1  one-cycle pulse when timer reaches 0

## Operation
- Map, binary-coded:
  - 0 ctrl: bit0 run, bit1 timer_run, bit7 sticky overrun
  - 1 sec, 2 min, 3 hour, 4 day (1–31), 5 month (1–12), 6 year (0–99, meaning 2000–2099)
  - 9 timer sec, 10 timer min, 11 timer hour
  - 12 ptr mirror (read-only)
  - all other addresses: general storage
- Reset:
  - all words 0, except day = 1 and month = 1
  - rd_data_a/b = 0
  - timer_done = 0
  - tick pending flag = 0
- Write: when wr_en, mem[wr_addr] <= wr_data on the next edge.
  - Writes to 12 are ignored; 12 <= {0, ptr_in} every cycle.
  - Writing ctrl bit7 with 0 clears overrun.
- Tick handling (FSM IDLE/PEND):
  - A tick in IDLE with wr_en = 0: advance this cycle.
  - A tick with wr_en = 1: enter PEND. Advance in the first cycle where wr_en = 0, then return to IDLE.
  - A tick arriving while in PEND is dropped and sets ctrl bit7.
- Calendar advance (only when run = 1):
  - sec+1; if sec ≥ 59: sec = 0 and carry to min.
  - min and hour cascade the same way, with limits 59 and 23.
  - day ≥ dim(month, year): day = 1 and carry to month.
  - month ≥ 12: month = 1 and carry to year.
  - year ≥ 99: year = 0.
  - dim: 31/30 per month; February is 29 when year % 4 == 0, else 28.
  - Out-of-range written values use the same ≥ compares, so they wrap on the next advance.
- Timer (TIMER_EN = 1, timer_run = 1):
  - On an advance tick, decrement {hour, min, sec} with borrow (sec 0 → 59, min 0 → 59).
  - This is independent of run.
  - When the decremented value equals 0: clear timer_run, and pulse timer_done for 1 cycle on the same edge.
  - timer_run = 1 with value already 0: clear timer_run on the next advance, with no pulse.
- Write to a field in the same cycle as its advance cannot occur, because the advance is deferred while wr_en = 1.

## Timing
- Read latency 1 cycle: rd_data_x <= mem[rd_addr_x].
- A same-cycle write to the same address returns the old data; the new value is visible the following cycle.
- Advance takes effect on the edge of the tick cycle, or of the first wr_en = 0 cycle when pending.
- Readback of an advanced field is visible 1 cycle later.
- ptr mirror lags ptr_in by 1 cycle; its readback lags by 2.
- reset asserted mid-operation overrides write, pending tick and timer on that edge.

## Structure
- Package rtc_pkg holds:
  - address constants: ADR_CTRL, ADR_SEC … ADR_YEAR, ADR_TSEC … ADR_THOUR, ADR_PTR
  - ctrl bit indices
  - field limit constants (59, 23, 12, 99)
  - function days_in_month(month, year)
  - FSM state enum (IDLE, PEND)
- One sub-module, rtc_time_next: combinational next-value of calendar and timer fields given current values and enables. Keeps cascade logic testable apart from the storage/port logic.

## Test plan
- Reset, then read 4 and 5 → 1 and 1; read all others → 0; timer_done = 0.
- Write sec = 58, min = 59, hour = 23, day = 31, month = 12, year = 99, run = 1; apply 2 ticks → all fields roll: sec 0, min 0, hour 0, day 1, month 1, year 0.
- year = 24, month = 2, day = 28, time 23:59:59, 1 tick → day 29; repeat with year = 25 → day 1, month 3.
- Tick in the same cycle as wr_en = 1, with wr_en held for 3 cycles → advance lands in the cycle after wr_en drops.
  - A second tick during PEND → ctrl bit7 = 1.
  - Writing ctrl = 0x01 → bit7 = 0.
- Timer 0:0:2, timer_run = 1, 2 ticks → 0:0:1, then 0:0:0; timer_done pulses on the second tick; ctrl bit1 = 0.
- Port A reads addr 3 while addr 3 is written 0x11 → old value; next cycle 0x11.
  - ptr_in = 5 → address 12 reads 5 after 2 cycles.
  - A write to 12 has no effect.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared constants, types and helpers for the RTC register file and calendar.
package rtc_pkg;

  // Register map (word addresses)
  localparam int ADR_CTRL  = 0;
  localparam int ADR_SEC   = 1;
  localparam int ADR_MIN   = 2;
  localparam int ADR_HOUR  = 3;
  localparam int ADR_DAY   = 4;
  localparam int ADR_MONTH = 5;
  localparam int ADR_YEAR  = 6;
  localparam int ADR_TSEC  = 9;
  localparam int ADR_TMIN  = 10;
  localparam int ADR_THOUR = 11;
  localparam int ADR_PTR   = 12;

  // Control word bit positions
  localparam int CTRL_RUN  = 0;
  localparam int CTRL_TRUN = 1;
  localparam int CTRL_OVR  = 7;

  // Field limits; a field at or above its limit wraps on the next advance
  localparam logic [7:0] LIM_SEC   = 8'd59;
  localparam logic [7:0] LIM_MIN   = 8'd59;
  localparam logic [7:0] LIM_HOUR  = 8'd23;
  localparam logic [7:0] LIM_MONTH = 8'd12;
  localparam logic [7:0] LIM_YEAR  = 8'd99;

  // Tick deferral state: a tick that collides with a host write waits in PEND
  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } tick_state_e;

  // Month length for years 2000-2099, where every year divisible by 4 is leap.
  // Out-of-range months fall back to 31 so the >= compare still wraps them.
  function automatic logic [7:0] days_in_month(input logic [7:0] month,
                                               input logic [7:0] year);
    logic [7:0] dim;
    case (month)
      8'd2:                    dim = (year[1:0] == 2'b00) ? 8'd29 : 8'd28;
      8'd4, 8'd6, 8'd9, 8'd11: dim = 8'd30;
      default:                 dim = 8'd31;
    endcase
    return dim;
  endfunction

endpackage

// File: rtl/rtc_time_next.sv
// Combinational next value of the calendar fields and of the countdown timer.
module rtc_time_next
  import rtc_pkg::*;
(
  input  logic       cal_en_i,
  input  logic       tmr_en_i,
  input  logic [7:0] sec_i,
  input  logic [7:0] min_i,
  input  logic [7:0] hour_i,
  input  logic [7:0] day_i,
  input  logic [7:0] month_i,
  input  logic [7:0] year_i,
  input  logic [7:0] tsec_i,
  input  logic [7:0] tmin_i,
  input  logic [7:0] thour_i,
  output logic [7:0] sec_o,
  output logic [7:0] min_o,
  output logic [7:0] hour_o,
  output logic [7:0] day_o,
  output logic [7:0] month_o,
  output logic [7:0] year_o,
  output logic [7:0] tsec_o,
  output logic [7:0] tmin_o,
  output logic [7:0] thour_o,
  output logic       tmr_stop_o,
  output logic       tmr_done_o
);

  logic carry;

  // Calendar cascade: each field wraps at its limit and carries into the next
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    sec_o   = sec_i;
    min_o   = min_i;
    hour_o  = hour_i;
    day_o   = day_i;
    month_o = month_i;
    year_o  = year_i;
    carry   = 1'b0;
    if (cal_en_i) begin
      // NOTE: carry is a blocking temporary; each stage must see the value just computed above it.
      if (sec_i >= LIM_SEC) begin
        sec_o = 8'd0;
        carry = 1'b1;
      end else begin
        sec_o = sec_i + 8'd1;
      end
      if (carry) begin
        if (min_i >= LIM_MIN) begin
          min_o = 8'd0;
        end else begin
          min_o = min_i + 8'd1;
          carry = 1'b0;
        end
      end
      if (carry) begin
        if (hour_i >= LIM_HOUR) begin
          hour_o = 8'd0;
        end else begin
          hour_o = hour_i + 8'd1;
          carry  = 1'b0;
        end
      end
      if (carry) begin
        if (day_i >= days_in_month(month_i, year_i)) begin
          day_o = 8'd1;
        end else begin
          day_o = day_i + 8'd1;
          carry = 1'b0;
        end
      end
      if (carry) begin
        if (month_i >= LIM_MONTH) begin
          month_o = 8'd1;
        end else begin
          month_o = month_i + 8'd1;
          carry   = 1'b0;
        end
      end
      if (carry) begin
        year_o = (year_i >= LIM_YEAR) ? 8'd0 : year_i + 8'd1;
      end
    end
  end

  // Timer countdown with borrow; stops (and flags done) when it lands on zero
  always_comb begin
    tsec_o     = tsec_i;
    tmin_o     = tmin_i;
    thour_o    = thour_i;
    tmr_stop_o = 1'b0;
    tmr_done_o = 1'b0;
    if (tmr_en_i) begin
      if ({thour_i, tmin_i, tsec_i} == 24'd0) begin
        // Armed at zero: just disarm, nothing counted down so no done pulse
        tmr_stop_o = 1'b1;
      end else begin
        if (tsec_i != 8'd0) begin
          tsec_o = tsec_i - 8'd1;
        end else begin
          tsec_o = LIM_SEC;
          if (tmin_i != 8'd0) begin
            tmin_o = tmin_i - 8'd1;
          end else begin
            tmin_o  = LIM_MIN;
            thour_o = thour_i - 8'd1;
          end
        end
        if ({thour_o, tmin_o, tsec_o} == 24'd0) begin
          tmr_stop_o = 1'b1;
          tmr_done_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rtc_regfile_calendar.sv
// RTC register file: one write port, two registered read ports, tick-driven
// calendar/timer advance deferred around host writes, pointer mirror.
module rtc_regfile_calendar
  import rtc_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int TIMER_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic [3:0]        ptr_in,
  output logic              timer_done
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] A_CTRL  = ADDR_W'(ADR_CTRL);
  localparam logic [ADDR_W-1:0] A_SEC   = ADDR_W'(ADR_SEC);
  localparam logic [ADDR_W-1:0] A_MIN   = ADDR_W'(ADR_MIN);
  localparam logic [ADDR_W-1:0] A_HOUR  = ADDR_W'(ADR_HOUR);
  localparam logic [ADDR_W-1:0] A_DAY   = ADDR_W'(ADR_DAY);
  localparam logic [ADDR_W-1:0] A_MONTH = ADDR_W'(ADR_MONTH);
  localparam logic [ADDR_W-1:0] A_YEAR  = ADDR_W'(ADR_YEAR);
  localparam logic [ADDR_W-1:0] A_TSEC  = ADDR_W'(ADR_TSEC);
  localparam logic [ADDR_W-1:0] A_TMIN  = ADDR_W'(ADR_TMIN);
  localparam logic [ADDR_W-1:0] A_THOUR = ADDR_W'(ADR_THOUR);
  localparam logic [ADDR_W-1:0] A_PTR   = ADDR_W'(ADR_PTR);

  // Time fields only hold 8 significant bits; wider words read 0 above them
  localparam logic [DATA_W-1:0] TIME_MASK = DATA_W'(8'hFF);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  tick_state_e       state_q;
  logic [DATA_W-1:0] rd_data_a_q;
  logic [DATA_W-1:0] rd_data_b_q;
  logic              timer_done_q;

  logic       adv;
  logic       cal_en;
  logic       tmr_en;
  logic [7:0] sec_n, min_n, hour_n, day_n, month_n, year_n;
  logic [7:0] tsec_n, tmin_n, thour_n;
  logic       tmr_stop, tmr_done;

  assign rd_data_a  = rd_data_a_q;
  assign rd_data_b  = rd_data_b_q;
  assign timer_done = timer_done_q;

  function automatic logic is_time_addr(input logic [ADDR_W-1:0] a);
    logic t;
    t = (a >= A_SEC) && (a <= A_YEAR);
    if (TIMER_EN != 0) t = t || ((a >= A_TSEC) && (a <= A_THOUR));
    return t;
  endfunction

  // Advance on a fresh tick with no write, or on the first write-free cycle while pending
  always_comb begin
    adv    = !wr_en && (((state_q == IDLE) && tick) || (state_q == PEND));
    cal_en = adv && mem_q[A_CTRL][CTRL_RUN];
    tmr_en = adv && (TIMER_EN != 0) && mem_q[A_CTRL][CTRL_TRUN];
  end

  rtc_time_next u_time_next (
    .cal_en_i   (cal_en),
    .tmr_en_i   (tmr_en),
    .sec_i      (mem_q[A_SEC][7:0]),
    .min_i      (mem_q[A_MIN][7:0]),
    .hour_i     (mem_q[A_HOUR][7:0]),
    .day_i      (mem_q[A_DAY][7:0]),
    .month_i    (mem_q[A_MONTH][7:0]),
    .year_i     (mem_q[A_YEAR][7:0]),
    .tsec_i     (mem_q[A_TSEC][7:0]),
    .tmin_i     (mem_q[A_TMIN][7:0]),
    .thour_i    (mem_q[A_THOUR][7:0]),
    .sec_o      (sec_n),
    .min_o      (min_n),
    .hour_o     (hour_n),
    .day_o      (day_n),
    .month_o    (month_n),
    .year_o     (year_n),
    .tsec_o     (tsec_n),
    .tmin_o     (tmin_n),
    .thour_o    (thour_n),
    .tmr_stop_o (tmr_stop),
    .tmr_done_o (tmr_done)
  );

  // Next contents of the register file: host write, advance, overrun flag, pointer mirror
  always_comb begin
    mem_d = mem_q;
    // A write and an advance never share a cycle, so their order here is irrelevant
    if (wr_en && (wr_addr != A_PTR)) begin
      mem_d[wr_addr] = is_time_addr(wr_addr) ? (wr_data & TIME_MASK) : wr_data;
    end
    if (cal_en) begin
      mem_d[A_SEC]   = DATA_W'(sec_n);
      mem_d[A_MIN]   = DATA_W'(min_n);
      mem_d[A_HOUR]  = DATA_W'(hour_n);
      mem_d[A_DAY]   = DATA_W'(day_n);
      mem_d[A_MONTH] = DATA_W'(month_n);
      mem_d[A_YEAR]  = DATA_W'(year_n);
    end
    if (tmr_en) begin
      mem_d[A_TSEC]  = DATA_W'(tsec_n);
      mem_d[A_TMIN]  = DATA_W'(tmin_n);
      mem_d[A_THOUR] = DATA_W'(thour_n);
      if (tmr_stop) mem_d[A_CTRL][CTRL_TRUN] = 1'b0;
    end
    // Overrun is set after the host write so a same-cycle ctrl write cannot hide it
    if ((state_q == PEND) && tick) mem_d[A_CTRL][CTRL_OVR] = 1'b1;
    mem_d[A_PTR] = DATA_W'(ptr_in);
  end

  // Storage, tick FSM, registered read ports and done pulse
  always_ff @(posedge clk) begin
    // NOTE: all state uses non-blocking assignment so every register samples pre-edge values.
    if (reset) begin
      // NOTE: the whole array is reset on purpose; the calendar needs a defined start date.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= ((i == ADR_DAY) || (i == ADR_MONTH)) ? DATA_W'(1) : '0;
      end
      state_q      <= IDLE;
      rd_data_a_q  <= '0;
      rd_data_b_q  <= '0;
      timer_done_q <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      rd_data_a_q  <= mem_q[rd_addr_a];
      rd_data_b_q  <= mem_q[rd_addr_b];
      timer_done_q <= tmr_done;
      case (state_q)
        IDLE:    if (tick && wr_en) state_q <= PEND;
        PEND:    if (!wr_en)        state_q <= IDLE;
        default:                    state_q <= IDLE;
      endcase
    end
  end

endmodule
